// File: rtl/neander_core.sv
// Neander accumulator CPU: datapath registers plus fetch/decode/execute control,
// talking to memory over a req/ack port that tolerates wait states.
module neander_core #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ac,
    output logic          n_flag,
    output logic          z_flag,
    output logic [3:0]    opcode,
    output logic          halted
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPRD, S_EXEC, S_OPWR, S_HALT
    } state_t;

    state_t        state, state_n;
    logic [AW-1:0] rem, rem_n, pc_n;
    logic [DW-1:0] rdm, rdm_n, ac_n, result;
    logic [3:0]    ri_n;
    logic          n_n, z_n, upd_flags, ack_c;

    // Next-state and datapath updates; ack only counts while a request is out
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        rem_n     = rem;
        rdm_n     = rdm;
        ri_n      = opcode;
        ac_n      = ac;
        n_n       = n_flag;
        z_n       = z_flag;
        result    = ac;
        upd_flags = 1'b0;
        ack_c     = mem_req && mem_ack;

        case (state)
            S_FETCH: begin
                if (ack_c) begin
                    rdm_n   = mem_rdata;
                    ri_n    = mem_rdata[DW-1 -: 4];
                    pc_n    = pc + AW'(1);
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_FETCH;
                case (opcode)
                    OP_STA: begin
                        rem_n   = rdm[AW-1:0];
                        state_n = S_OPWR;
                    end
                    OP_LDA, OP_ADD, OP_OR, OP_AND: begin
                        rem_n   = rdm[AW-1:0];
                        state_n = S_OPRD;
                    end
                    OP_NOT: state_n = S_EXEC;
                    OP_JMP: pc_n = rdm[AW-1:0];
                    OP_JN:  if (n_flag) pc_n = rdm[AW-1:0];
                    OP_JZ:  if (z_flag) pc_n = rdm[AW-1:0];
                    OP_HLT: state_n = S_HALT;
                    default: state_n = S_FETCH;
                endcase
            end
            S_OPRD: begin
                if (ack_c) begin
                    rdm_n   = mem_rdata;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                upd_flags = 1'b1;
                case (opcode)
                    OP_LDA:  result = rdm;
                    OP_ADD:  result = ac + rdm;
                    OP_OR:   result = ac | rdm;
                    OP_AND:  result = ac & rdm;
                    OP_NOT:  result = ~ac;
                    default: upd_flags = 1'b0;
                endcase
                if (upd_flags) begin
                    ac_n = result;
                    n_n  = result[DW-1];
                    z_n  = (result == '0);
                end
                state_n = S_FETCH;
            end
            S_OPWR:  if (ack_c) state_n = S_FETCH;
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase
    end

    // Memory port is registered from next-state values so it is held steady across waits
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= AW'(RESET_PC);
            rem       <= '0;
            rdm       <= '0;
            opcode    <= '0;
            ac        <= '0;
            n_flag    <= 1'b0;
            z_flag    <= 1'b0;
            halted    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= AW'(RESET_PC);
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            rem       <= rem_n;
            rdm       <= rdm_n;
            opcode    <= ri_n;
            ac        <= ac_n;
            n_flag    <= n_n;
            z_flag    <= z_n;
            halted    <= (state_n == S_HALT);
            mem_req   <= (state_n == S_FETCH) || (state_n == S_OPRD) || (state_n == S_OPWR);
            mem_we    <= (state_n == S_OPWR);
            mem_addr  <= (state_n == S_FETCH) ? pc_n : rem_n;
            mem_wdata <= ac_n;
        end
    end

endmodule

// File: tb/tb_neander_core.sv
// Directed bench for neander_core: reset, program run, branches, wait states,
// illegal opcode with PC wrap, and a 24/12-bit instance.
module tb_neander_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_wdata, mem_rdata, ac;
    logic        n_flag, z_flag, halted;
    logic [3:0]  opcode;

    logic        req2, we2, ack2, n2, z2, halt2;
    logic [11:0] addr2, pc2;
    logic [23:0] wdata2, rdata2, ac2;
    logic [3:0]  op2;

    logic [15:0] mem [256];
    logic [23:0] mem2 [4096];

    int n_cmp = 0;
    int n_err = 0;
    int wait_n = 0;
    int cnt = 0;
    logic hold_ack = 1'b0;

    int acc_cnt = 0, wr_cnt = 0, stab_err = 0, hld_cnt = 0;
    logic [7:0]  last_waddr = '0, h_addr = '0;
    logic [15:0] last_wdata = '0, h_wd = '0;
    logic        hold_v = 1'b0, h_we = 1'b0;

    always #5 clk = ~clk;

    neander_core #(.DW(16), .AW(8), .RESET_PC(0)) u_dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc), .ac(ac),
        .n_flag(n_flag), .z_flag(z_flag), .opcode(opcode), .halted(halted)
    );

    neander_core #(.DW(24), .AW(12), .RESET_PC(0)) u_dut24 (
        .clk(clk), .rst(rst), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ack(ack2), .pc(pc2), .ac(ac2),
        .n_flag(n2), .z_flag(z2), .opcode(op2), .halted(halt2)
    );

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && !hold_ack && (cnt == wait_n);
    assign rdata2    = mem2[addr2];
    assign ack2      = req2;

    // Memory-side monitor: access/write log, wait counter, port stability during waits
    always @(posedge clk) begin
        if (rst) begin
            cnt    <= 0;
            hold_v <= 1'b0;
        end else begin
            if (mem_req && mem_ack) begin
                acc_cnt <= acc_cnt + 1;
                if (mem_we) begin
                    wr_cnt     <= wr_cnt + 1;
                    last_waddr <= mem_addr;
                    last_wdata <= mem_wdata;
                end
            end
            if (mem_req && !mem_ack) hld_cnt <= hld_cnt + 1;
            cnt <= (!mem_req || mem_ack) ? 0 : cnt + 1;
            if (hold_v && (!mem_req || mem_addr !== h_addr || mem_we !== h_we ||
                           (h_we && mem_wdata !== h_wd)))
                stab_err <= stab_err + 1;
            hold_v <= mem_req && !mem_ack;
            h_addr <= mem_addr;
            h_we   <= mem_we;
            h_wd   <= mem_wdata;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req); end
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL rst_pc: got %h want 00", pc); end
        n_cmp++; if (ac !== 16'h0000) begin n_err++; $display("FAIL rst_ac: got %h want 0000", ac); end
        n_cmp++; if ({n_flag, z_flag, halted} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {n_flag, z_flag, halted}); end
        n_cmp++; if (opcode !== 4'h0) begin n_err++; $display("FAIL rst_opcode: got %h want 0", opcode); end
        rst = 1'b0;
        step(1);
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h00}) begin n_err++; $display("FAIL rst_first_req: got req=%b we=%b addr=%h want 1/0/00", mem_req, mem_we, mem_addr); end
    endtask

    // LDA 0x80; ADD 0x81; STA 0x82; HLT with 0x0005 + 0xFFFB = 0x0000
    task automatic test_program(input int w);
        int cyc;
        int wr0;
        clear_mem();
        mem[8'h00] = 16'h2080; mem[8'h01] = 16'h3081; mem[8'h02] = 16'h1082; mem[8'h03] = 16'hF000;
        mem[8'h80] = 16'h0005; mem[8'h81] = 16'hFFFB; mem[8'h82] = 16'hDEAD;
        wait_n = w;
        wr0 = wr_cnt;
        do_reset();
        step(1);
        cyc = 0;
        while (!halted && cyc < 400) begin step(1); cyc++; end
        n_cmp++; if (cyc !== 13 + 7 * w) begin n_err++; $display("FAIL prog_cycles(w=%0d): got %0d want %0d", w, cyc, 13 + 7 * w); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL prog_halted: got %b want 1", halted); end
        n_cmp++; if (pc !== 8'h04) begin n_err++; $display("FAIL prog_pc: got %h want 04", pc); end
        n_cmp++; if (ac !== 16'h0000) begin n_err++; $display("FAIL prog_ac: got %h want 0000", ac); end
        n_cmp++; if ({n_flag, z_flag} !== 2'b01) begin n_err++; $display("FAIL prog_nz: got %b want 01", {n_flag, z_flag}); end
        n_cmp++; if (opcode !== 4'hF) begin n_err++; $display("FAIL prog_opcode: got %h want F", opcode); end
        n_cmp++; if (wr_cnt - wr0 !== 1) begin n_err++; $display("FAIL prog_wr_count: got %0d want 1", wr_cnt - wr0); end
        n_cmp++; if ({last_waddr, last_wdata} !== {8'h82, 16'h0000}) begin n_err++; $display("FAIL prog_write: got %h<=%h want 82<=0000", last_waddr, last_wdata); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL prog_halt_req: got %b want 0", mem_req); end
        wait_n = 0;
    endtask

    task automatic load_branch_prog();
        clear_mem();
        mem[8'h00] = 16'h2080; mem[8'h01] = 16'h9010; mem[8'h80] = 16'h8000;
        mem[8'h10] = 16'hA020; mem[8'h11] = 16'h6000; mem[8'h12] = 16'hF000;
    endtask

    task automatic test_branches();
        load_branch_prog();
        do_reset();
        step(7);
        n_cmp++; if (pc !== 8'h10) begin n_err++; $display("FAIL jn_taken_pc: got %h want 10", pc); end
        n_cmp++; if ({ac, n_flag, z_flag} !== {16'h8000, 2'b10}) begin n_err++; $display("FAIL lda_8000: got ac=%h n=%b z=%b want 8000/1/0", ac, n_flag, z_flag); end
        step(2);
        n_cmp++; if (pc !== 8'h11) begin n_err++; $display("FAIL jz_not_taken_pc: got %h want 11", pc); end
        step(3);
        n_cmp++; if (ac !== 16'h7FFF) begin n_err++; $display("FAIL not_ac: got %h want 7FFF", ac); end
        n_cmp++; if ({n_flag, z_flag} !== 2'b00) begin n_err++; $display("FAIL not_nz: got %b want 00", {n_flag, z_flag}); end
        step(2);
        n_cmp++; if ({halted, pc} !== {1'b1, 8'h13}) begin n_err++; $display("FAIL br_halt: got halted=%b pc=%h want 1/13", halted, pc); end
    endtask

    task automatic test_reset_mid_fetch();
        load_branch_prog();
        do_reset();
        step(7);
        hold_ack = 1'b1;
        step(2);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h10}) begin n_err++; $display("FAIL mid_pending: got req=%b addr=%h want 1/10", mem_req, mem_addr); end
        rst = 1'b1;
        step(1);
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL mid_req_drop: got %b want 0", mem_req); end
        n_cmp++; if ({pc, ac} !== 24'h000000) begin n_err++; $display("FAIL mid_pc_ac: got pc=%h ac=%h want 00/0000", pc, ac); end
        n_cmp++; if ({n_flag, z_flag, halted} !== 3'b000) begin n_err++; $display("FAIL mid_flags: got %b want 000", {n_flag, z_flag, halted}); end
        rst = 1'b0;
        hold_ack = 1'b0;
        step(1);
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL mid_restart: got req=%b addr=%h want 1/00", mem_req, mem_addr); end
    endtask

    task automatic test_wait_states();
        int se0;
        int hc0;
        se0 = stab_err;
        hc0 = hld_cnt;
        test_program(3);
        n_cmp++; if (stab_err - se0 !== 0) begin n_err++; $display("FAIL wait_stability: got %0d unstable cycles want 0", stab_err - se0); end
        n_cmp++; if (hld_cnt - hc0 !== 21) begin n_err++; $display("FAIL wait_cycles: got %0d wait cycles want 21", hld_cnt - hc0); end
    endtask

    // LDA 0x80 (0x8001); JMP 0xFF; illegal 0xB123 at 0xFF wraps PC to 0
    task automatic test_illegal();
        int a0;
        int w0;
        clear_mem();
        mem[8'h00] = 16'h2080; mem[8'h01] = 16'h80FF; mem[8'h80] = 16'h8001; mem[8'hFF] = 16'hB123;
        do_reset();
        step(7);
        n_cmp++; if (pc !== 8'hFF) begin n_err++; $display("FAIL ill_jmp_pc: got %h want FF", pc); end
        a0 = acc_cnt;
        w0 = wr_cnt;
        step(1);
        n_cmp++; if ({pc, opcode} !== {8'h00, 4'hB}) begin n_err++; $display("FAIL ill_wrap: got pc=%h op=%h want 00/B", pc, opcode); end
        step(1);
        n_cmp++; if (acc_cnt - a0 !== 1 || wr_cnt !== w0) begin n_err++; $display("FAIL ill_accesses: got %0d acc %0d wr want 1/0", acc_cnt - a0, wr_cnt - w0); end
        n_cmp++; if ({ac, n_flag, z_flag} !== {16'h8001, 2'b10}) begin n_err++; $display("FAIL ill_state: got ac=%h n=%b z=%b want 8001/1/0", ac, n_flag, z_flag); end
        n_cmp++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h00}) begin n_err++; $display("FAIL ill_next_fetch: got req=%b we=%b addr=%h want 1/0/00", mem_req, mem_we, mem_addr); end
    endtask

    task automatic test_sweep();
        int cyc;
        for (int i = 0; i < 4096; i++) mem2[i] = 24'h000000;
        mem2[12'h000] = 24'h200ABC; mem2[12'h001] = 24'hF00000; mem2[12'hABC] = 24'h800000;
        do_reset();
        step(1);
        step(1);
        n_cmp++; if (op2 !== 4'h2) begin n_err++; $display("FAIL w24_opcode: got %h want 2", op2); end
        cyc = 1;
        while (!halt2 && cyc < 100) begin step(1); cyc++; end
        n_cmp++; if (cyc !== 6) begin n_err++; $display("FAIL w24_cycles: got %0d want 6", cyc); end
        n_cmp++; if (ac2 !== 24'h800000) begin n_err++; $display("FAIL w24_ac: got %h want 800000", ac2); end
        n_cmp++; if ({n2, z2} !== 2'b10) begin n_err++; $display("FAIL w24_nz: got %b want 10", {n2, z2}); end
        n_cmp++; if ({pc2, op2} !== {12'h002, 4'hF}) begin n_err++; $display("FAIL w24_halt: got pc=%h op=%h want 002/F", pc2, op2); end
    endtask

    initial begin
        clear_mem();
        for (int i = 0; i < 4096; i++) mem2[i] = 24'h000000;
        test_reset();
        test_program(0);
        test_branches();
        test_reset_mid_fetch();
        test_wait_states();
        test_illegal();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/neander_core.md
Name: neander_core

Overview:
- Parametrised successor to the fixed 16-bit/8-bit Neander datapath.
- Integrates datapath registers (PC, REM, RDM, RI, AC, N/Z) with the fetch/decode/execute control FSM in one block.
- Replaces the internal RAM with an external req/ack memory port so wait-state memories and shared buses attach directly.
- Opcode comes from RDM[DW-1:DW-4]; operand/jump address from RDM[AW-1:0].

Parameters:
- DW, 16, data/instruction word width; legal range DW >= AW+4.
- AW, 8, address width; PC and REM are AW bits.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  access address (REM); stable while mem_req=1.
- mem_wdata  out  DW  write data (AC); valid while mem_req=1 && mem_we=1.
- mem_rdata  in  DW  read data; sampled only in a cycle with mem_req && mem_ack && !mem_we.
- mem_ack  in  1  access completes this cycle; may be high in the first req cycle; ignored when mem_req=0.
- pc  out  AW  current PC.
- ac  out  DW  current AC.
- n_flag  out  1  registered N flag.
- z_flag  out  1  registered Z flag.
- opcode  out  4  current RI.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (rst=1 at an edge):
  - PC=RESET_PC; REM, RDM, RI, AC=0; n_flag=0; z_flag=0; halted=0; state=FETCH.
  - mem_req=0 during the cycle after reset, including reset mid-transaction; the pending access is abandoned.
- FSM states: FETCH, DECODE, OPRD, EXEC, OPWR, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On ack: RDM<=mem_rdata, RI<=mem_rdata[DW-1:DW-4], PC<=PC+1 (wraps modulo 2^AW), go to DECODE.
- DECODE (1 cycle, no memory request), dispatch on RI:
  - 0 NOP -> FETCH.
  - 1 STA -> REM<=RDM[AW-1:0], go to OPWR.
  - 2 LDA, 3 ADD, 4 OR, 5 AND -> REM<=RDM[AW-1:0], go to OPRD.
  - 6 NOT -> EXEC.
  - 8 JMP -> PC<=RDM[AW-1:0], go to FETCH.
  - 9 JN -> PC<=RDM[AW-1:0] if n_flag, else PC unchanged; go to FETCH.
  - A JZ -> same as JN, using z_flag.
  - F HLT -> HALT.
  - 7, B, C, D, E: treated as NOP; no state side effects.
- OPRD: mem_req=1, mem_we=0, mem_addr=REM. On ack: RDM<=mem_rdata, go to EXEC.
- EXEC (1 cycle):
  - AC <= LDA: RDM; ADD: AC+RDM mod 2^DW (carry discarded); OR: AC|RDM; AND: AC&RDM; NOT: ~AC.
  - Same edge: n_flag<=result[DW-1]; z_flag<=(result==0).
  - Then go to FETCH.
- OPWR: mem_req=1, mem_we=1, mem_addr=REM, mem_wdata=AC. On ack go to FETCH. Flags unchanged.
- HALT: halted=1, mem_req=0; stays in HALT until rst.
- Flags change only in EXEC.
- AC changes only in EXEC or on reset.
- Cycle counts with zero-wait memory (ack in first req cycle):
  - NOP/JMP/JN/JZ/illegal: 2 cycles.
  - NOT: 3 cycles.
  - LDA/ADD/OR/AND: 4 cycles.
  - STA: 3 cycles.
  - Each wait cycle adds 1.
- Memory port stability: mem_addr, mem_we and mem_wdata stay constant from req assertion through the ack cycle. mem_req drops in the cycle after ack, except that FETCH may follow OPWR/EXEC with a new request whose address differs.
- PC wrap: fetch at address 2^AW-1 yields PC=0.

Test Plan:
- Reset mid-fetch: assert rst while mem_req=1, ack held low -> next cycle mem_req=0, pc=0, ac=0, n_flag=0, z_flag=0, halted=0; first post-reset request has mem_addr=0.
- Program (DW=16, AW=8): mem[0]=0x2080 LDA, mem[1]=0x3081 ADD, mem[2]=0x1082 STA, mem[3]=0xF000 HLT; mem[0x80]=0x0005, mem[0x81]=0xFFFB -> write of 0x0000 to 0x82, z_flag=1, n_flag=0, halted=1, pc=4; zero-wait total = 4+4+3+2 cycles to reach HALT.
- Branches: AC=0x8000 via LDA, then JN 0x10 -> pc=0x10; JZ 0x20 not taken -> pc increments by 1; NOT -> ac=0x7FFF, n_flag=0, z_flag=0.
- Wait states: ack delayed 3 cycles on every access -> mem_addr/mem_we/mem_wdata stable across the waits; results identical to zero-wait run; each access 3 cycles longer.
- Illegal opcode 0xB123 at PC=0xFF -> no memory access beyond fetch, ac/flags unchanged, pc wraps to 0x00, next fetch at address 0.
- Parameter sweep DW=24, AW=12: LDA from 0xABC with word 0x800000 -> ac=0x800000, n_flag=1; opcode taken from bits [23:20].
